// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage LC-3b pipeline.
// Combinational outputs from state + inputs; state and counters update on clk.
// Optional counters: define STALL_PERF_CNT_EN to build the perf_* counters.
module pipeline_stall_ctrl #(
    parameter int BUBBLE_CYCLES = 1,   // load-use bubbles per hazard, legal 1..7
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bubble_enable,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    input  logic                 branch_taken,
    input  logic                 perf_clr,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 bubble_id_ex,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic                 stall_active,
    output logic [CNT_WIDTH-1:0] perf_dstall_cnt,
    output logic [CNT_WIDTH-1:0] perf_istall_cnt,
    output logic [CNT_WIDTH-1:0] perf_bubble_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
);

    typedef enum logic {S_RUN, S_BUBBLE} state_t;

    // Counter preload on entering S_BUBBLE: the first bubble is spent in S_RUN.
    localparam logic [2:0] BUBBLE_LAST = 3'(BUBBLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic dstall, istall, bubble_req;
    logic ld_front, ld_back, bub, flush;
    logic hit_dstall, hit_istall, hit_bubble, hit_flush;

    assign dstall     = (dmem_read | dmem_write) & ~dmem_resp;
    assign istall     = imem_read & ~imem_resp;
    assign bubble_req = ((state_q == S_RUN) & bubble_enable) | (state_q == S_BUBBLE);

    // Priority resolution: D-cache stall, branch held by I-stall, redirect, I-stall, bubble, run.
    always_comb begin
        ld_front   = 1'b0;
        ld_back    = 1'b0;
        bub        = 1'b0;
        flush      = 1'b0;
        hit_dstall = 1'b0;
        hit_istall = 1'b0;
        hit_bubble = 1'b0;
        hit_flush  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (reset) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
        end else if (dstall) begin
            // Everything frozen; bubble sequence and any pending branch are held.
            hit_dstall = 1'b1;
        end else if (branch_taken && istall) begin
            // Keep the branch in MEM until fetch can accept the redirect.
            hit_istall = 1'b1;
        end else if (branch_taken) begin
            ld_front  = 1'b1;
            ld_back   = 1'b1;
            flush     = 1'b1;
            hit_flush = 1'b1;
            state_d   = S_RUN;
            cnt_d     = 3'd0;
        end else if (istall) begin
            hit_istall = 1'b1;
        end else if (bubble_req) begin
            ld_back    = 1'b1;
            bub        = 1'b1;
            hit_bubble = 1'b1;
            if (state_q == S_RUN) begin
                if (BUBBLE_CYCLES > 1) begin
                    state_d = S_BUBBLE;
                    cnt_d   = BUBBLE_LAST;
                end
            end else begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_RUN;
                end
            end
        end else begin
            ld_front = 1'b1;
            ld_back  = 1'b1;
        end
    end

    assign load_pc      = ld_front;
    assign load_if_id   = ld_front;
    assign load_id_ex   = ld_back;
    assign load_ex_mem  = ld_back;
    assign load_mem_wb  = ld_back;
    assign bubble_id_ex = bub;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;
    assign stall_active = ~reset & ~(ld_front & ld_back);

    // Bubble FSM state and remaining-bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] dstall_cnt_q, istall_cnt_q, bubble_cnt_q, flush_cnt_q;

    // Saturating event counters; a clear request beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            dstall_cnt_q <= '0;
            istall_cnt_q <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (hit_dstall && !(&dstall_cnt_q)) dstall_cnt_q <= dstall_cnt_q + CNT_ONE;
            if (hit_istall && !(&istall_cnt_q)) istall_cnt_q <= istall_cnt_q + CNT_ONE;
            if (hit_bubble && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            if (hit_flush  && !(&flush_cnt_q))  flush_cnt_q  <= flush_cnt_q  + CNT_ONE;
        end
    end

    assign perf_dstall_cnt = dstall_cnt_q;
    assign perf_istall_cnt = istall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`else
    // Counters not built: event strobes and the clear input have no consumer.
    logic [4:0] unused_perf;
    assign unused_perf = {perf_clr, hit_dstall, hit_istall, hit_bubble, hit_flush};

    assign perf_dstall_cnt = '0;
    assign perf_istall_cnt = '0;
    assign perf_bubble_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: one instance with 3-cycle bubbles driven by a
// vector table, plus a 1-cycle-bubble instance with 2-bit counters for saturation.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, bubble_enable, imem_read, imem_resp, dmem_read, dmem_write;
    logic dmem_resp, branch_taken, perf_clr;

    // Instance A: BUBBLE_CYCLES=3, 16-bit counters
    logic a_lpc, a_lifid, a_lidex, a_lexmem, a_lmemwb, a_bub, a_fifid, a_fidex, a_fexmem, a_stall;
    logic [15:0] a_dcnt, a_icnt, a_bcnt, a_fcnt;
    // Instance B: BUBBLE_CYCLES=1, 2-bit counters
    logic b_lpc, b_lifid, b_lidex, b_lexmem, b_lmemwb, b_bub, b_fifid, b_fidex, b_fexmem, b_stall;
    logic [1:0] b_dcnt, b_icnt, b_bcnt, b_fcnt;

    pipeline_stall_ctrl #(.BUBBLE_CYCLES(3), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .bubble_enable(bubble_enable),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .branch_taken(branch_taken), .perf_clr(perf_clr),
        .load_pc(a_lpc), .load_if_id(a_lifid), .load_id_ex(a_lidex),
        .load_ex_mem(a_lexmem), .load_mem_wb(a_lmemwb), .bubble_id_ex(a_bub),
        .flush_if_id(a_fifid), .flush_id_ex(a_fidex), .flush_ex_mem(a_fexmem),
        .stall_active(a_stall),
        .perf_dstall_cnt(a_dcnt), .perf_istall_cnt(a_icnt),
        .perf_bubble_cnt(a_bcnt), .perf_flush_cnt(a_fcnt)
    );

    pipeline_stall_ctrl #(.BUBBLE_CYCLES(1), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .bubble_enable(bubble_enable),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .branch_taken(branch_taken), .perf_clr(perf_clr),
        .load_pc(b_lpc), .load_if_id(b_lifid), .load_id_ex(b_lidex),
        .load_ex_mem(b_lexmem), .load_mem_wb(b_lmemwb), .bubble_id_ex(b_bub),
        .flush_if_id(b_fifid), .flush_id_ex(b_fidex), .flush_ex_mem(b_fexmem),
        .stall_active(b_stall),
        .perf_dstall_cnt(b_dcnt), .perf_istall_cnt(b_icnt),
        .perf_bubble_cnt(b_bcnt), .perf_flush_cnt(b_fcnt)
    );

    // Input bits: {reset, bubble_enable, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, branch_taken, perf_clr}
    localparam logic [8:0] I_NONE = 9'h000, I_RST = 9'h100, I_BE  = 9'h080, I_IRD = 9'h040;
    localparam logic [8:0] I_IRSP = 9'h020, I_DRD = 9'h010, I_DWR = 9'h008, I_DRSP = 9'h004;
    localparam logic [8:0] I_BR   = 9'h002, I_CLR = 9'h001;

    // Output bits: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, flush x3, stall_active}
    localparam logic [9:0] E_RST = 10'b00000_0_000_0;
    localparam logic [9:0] E_RUN = 10'b11111_0_000_0;
    localparam logic [9:0] E_FRZ = 10'b00000_0_000_1;
    localparam logic [9:0] E_BUB = 10'b00111_1_000_1;
    localparam logic [9:0] E_FLS = 10'b11111_0_111_0;

    typedef struct {
        logic [8:0] in;
        logic [9:0] exp;
        bit         chk;    // counters checked at this row (values accumulated before it)
        int         d, i, b, f;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t v(input logic [8:0] in, input logic [9:0] ex);
        vec_t r;
        r.in = in; r.exp = ex; r.chk = 1'b0; r.d = 0; r.i = 0; r.b = 0; r.f = 0;
        return r;
    endfunction

    function automatic vec_t vc(input logic [8:0] in, input logic [9:0] ex,
                                input int d, input int i, input int b, input int f);
        vec_t r;
        r.in = in; r.exp = ex; r.chk = 1'b1; r.d = d; r.i = i; r.b = b; r.f = f;
        return r;
    endfunction

    // Counter expectation: real value when counters are built, zero otherwise.
    function automatic int ce(input int val);
`ifdef STALL_PERF_CNT_EN
        return val;
`else
        return 0;
`endif
    endfunction

    function automatic logic [9:0] outs_a();
        return {a_lpc, a_lifid, a_lidex, a_lexmem, a_lmemwb, a_bub, a_fifid, a_fidex, a_fexmem, a_stall};
    endfunction

    function automatic logic [9:0] outs_b();
        return {b_lpc, b_lifid, b_lidex, b_lexmem, b_lmemwb, b_bub, b_fifid, b_fidex, b_fexmem, b_stall};
    endfunction

    task automatic drive(input logic [8:0] in);
        {reset, bubble_enable, imem_read, imem_resp, dmem_read, dmem_write,
         dmem_resp, branch_taken, perf_clr} = in;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Instance B stepping: drive, check outputs mid-cycle, advance one clock.
    task automatic step_b(input string name, input logic [8:0] in, input logic [9:0] ex);
        drive(in);
        @(negedge clk);
        check(name, 32'(outs_b()), 32'(ex));
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(I_RST);

        // Sequences for instance A (BUBBLE_CYCLES=3); state carries from row to row.
        tbl.push_back(v (I_RST, E_RST));                        // 0
        tbl.push_back(v (I_RST, E_RST));                        // 1
        tbl.push_back(vc(I_NONE, E_RUN, 0, 0, 0, 0));           // 2 clean after reset
        tbl.push_back(v (I_BE, E_BUB));                         // 3 load-use: 3 bubbles
        tbl.push_back(v (I_NONE, E_BUB));                       // 4
        tbl.push_back(v (I_BE, E_BUB));                         // 5 bubble_enable ignored in S_BUBBLE
        tbl.push_back(vc(I_NONE, E_RUN, 0, 0, 3, 0));           // 6
        tbl.push_back(v (I_IRD, E_FRZ));                        // 7 I-stall
        tbl.push_back(v (I_IRD | I_IRSP, E_RUN));               // 8
        tbl.push_back(vc(I_BE, E_BUB, 0, 1, 3, 0));             // 9 bubble, cnt -> 2
        tbl.push_back(v (I_DRD, E_FRZ));                        // 10 D-stall holds cnt
        tbl.push_back(v (I_DRD, E_FRZ));                        // 11
        tbl.push_back(v (I_DRD, E_FRZ));                        // 12
        tbl.push_back(v (I_DRD | I_DRSP, E_BUB));               // 13 bubbles resume
        tbl.push_back(v (I_NONE, E_BUB));                       // 14
        tbl.push_back(vc(I_NONE, E_RUN, 3, 1, 6, 0));           // 15
        tbl.push_back(v (I_DWR, E_FRZ));                        // 16 store stall
        tbl.push_back(v (I_DWR | I_DRSP, E_RUN));               // 17
        tbl.push_back(vc(I_BR | I_IRD, E_FRZ, 4, 1, 6, 0));     // 18 branch held by I-stall
        tbl.push_back(v (I_BR | I_IRD, E_FRZ));                 // 19
        tbl.push_back(v (I_BR | I_IRD | I_IRSP, E_FLS));        // 20 redirect
        tbl.push_back(vc(I_NONE, E_RUN, 4, 3, 6, 1));           // 21
        tbl.push_back(v (I_BE, E_BUB));                         // 22 enter S_BUBBLE cnt=2
        tbl.push_back(v (I_BR, E_FLS));                         // 23 branch aborts bubbles
        tbl.push_back(vc(I_NONE, E_RUN, 4, 3, 7, 2));           // 24
        tbl.push_back(v (I_NONE, E_RUN));                       // 25
        tbl.push_back(v (I_BR | I_DRD, E_FRZ));                 // 26 D-stall beats branch
        tbl.push_back(v (I_BR | I_DRD | I_DRSP, E_FLS));        // 27 branch re-evaluated
        tbl.push_back(vc(I_NONE, E_RUN, 5, 3, 7, 3));           // 28
        tbl.push_back(v (I_BE | I_IRD, E_FRZ));                 // 29 I-stall beats bubble
        tbl.push_back(v (I_BE, E_BUB));                         // 30
        tbl.push_back(v (I_IRD, E_FRZ));                        // 31 I-stall inside S_BUBBLE
        tbl.push_back(v (I_NONE, E_BUB));                       // 32
        tbl.push_back(v (I_NONE, E_BUB));                       // 33
        tbl.push_back(vc(I_NONE, E_RUN, 5, 5, 10, 3));          // 34
        tbl.push_back(v (I_BE, E_BUB));                         // 35 enter S_BUBBLE
        tbl.push_back(v (I_RST | I_BE, E_RST));                 // 36 reset mid-bubble
        tbl.push_back(vc(I_NONE, E_RUN, 0, 0, 0, 0));           // 37 no residual bubble
        tbl.push_back(v (I_DRD, E_FRZ));                        // 38
        tbl.push_back(vc(I_NONE, E_RUN, 1, 0, 0, 0));           // 39
        tbl.push_back(v (I_DRD | I_CLR, E_FRZ));                // 40 clear beats increment
        tbl.push_back(vc(I_NONE, E_RUN, 0, 0, 0, 0));           // 41

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].in);
            @(negedge clk);
            check($sformatf("a_row%0d_outs", k), 32'(outs_a()), 32'(tbl[k].exp));
            if (tbl[k].chk) begin
                check($sformatf("a_row%0d_dstall_cnt", k), 32'(a_dcnt), 32'(ce(tbl[k].d)));
                check($sformatf("a_row%0d_istall_cnt", k), 32'(a_icnt), 32'(ce(tbl[k].i)));
                check($sformatf("a_row%0d_bubble_cnt", k), 32'(a_bcnt), 32'(ce(tbl[k].b)));
                check($sformatf("a_row%0d_flush_cnt", k),  32'(a_fcnt), 32'(ce(tbl[k].f)));
            end
            @(posedge clk);
            #1;
        end

        // Instance B (BUBBLE_CYCLES=1, 2-bit counters).
        step_b("b_reset", I_RST, E_RST);
        step_b("b_bubble1", I_BE, E_BUB);
        drive(I_NONE);
        @(negedge clk);
        check("b_after_bubble_outs", 32'(outs_b()), 32'(E_RUN));
        check("b_bubble_cnt_1", 32'(b_bcnt), 32'(ce(1)));
        @(posedge clk);
        #1;
        step_b("b_bubble_back2back_0", I_BE, E_BUB);
        step_b("b_bubble_back2back_1", I_BE, E_BUB);
        step_b("b_run", I_NONE, E_RUN);
        for (int n = 0; n < 5; n++) begin
            step_b($sformatf("b_dstall_%0d", n), I_DRD, E_FRZ);
        end
        drive(I_NONE);
        @(negedge clk);
        check("b_final_outs", 32'(outs_b()), 32'(E_RUN));
        check("b_bubble_cnt_saturated", 32'(b_bcnt), 32'(ce(3)));
        check("b_dstall_cnt_saturated", 32'(b_dcnt), 32'(ce(3)));
        check("b_flush_cnt", 32'(b_fcnt), 32'(ce(0)));
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the load-use hazard signal in the 5-stage LC-3b pipeline.
- Takes the hazard detector's bubble_enable, I-cache/D-cache handshakes and the MEM-stage branch_taken.
- Drives every pipeline-register load enable, the ID/EX bubble insert and the squash signals.
- Holds a multi-cycle bubble counter so deeper memory stages can require more than one load-use bubble.

Parameters:
BUBBLE_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
bubble_enable  input  1  load-use hazard flag from the hazard detector (ID stage)
imem_read  input  1  fetch request outstanding
imem_resp  input  1  I-cache response this cycle
dmem_read  input  1  MEM-stage load request
dmem_write  input  1  MEM-stage store request
dmem_resp  input  1  D-cache response this cycle
branch_taken  input  1  MEM-stage redirect (br/jmp/jsr/trap resolved)
perf_clr  input  1  clears performance counters
load_pc  output  1  PC register enable
load_if_id  output  1  IF/ID enable
load_id_ex  output  1  ID/EX enable
load_ex_mem  output  1  EX/MEM enable
load_mem_wb  output  1  MEM/WB enable
bubble_id_ex  output  1  ID/EX loads a NOP instead of decoded instruction
flush_if_id  output  1  IF/ID loads NOP
flush_id_ex  output  1  ID/EX loads NOP
flush_ex_mem  output  1  EX/MEM loads NOP
stall_active  output  1  any load enable deasserted this cycle
perf_dstall_cnt  output  CNT_WIDTH  D-cache stall cycles
perf_istall_cnt  output  CNT_WIDTH  I-cache stall cycles
perf_bubble_cnt  output  CNT_WIDTH  bubbles inserted
perf_flush_cnt  output  CNT_WIDTH  redirects taken

Behaviour:
- Definitions: dstall = (dmem_read|dmem_write) & ~dmem_resp; istall = imem_read & ~imem_resp.
- Outputs are combinational from state and inputs. State is S_RUN/S_BUBBLE plus a 3-bit bubble counter cnt.
- Reset (checked at the clk edge): state S_RUN, cnt 0, counters 0. While reset is high, all load_*, bubble and flush outputs are 0 and stall_active is 0.
- Per-cycle priority, first match wins:
  1. dstall: all loads 0, bubble/flush 0. State, cnt and any pending branch are held, so branch_taken is re-evaluated after the stall.
  2. branch_taken & istall: all loads 0, flush 0, so the branch stays in MEM.
  3. branch_taken: all loads 1; flush_if_id, flush_id_ex, flush_ex_mem = 1; bubble_id_ex 0. Next state S_RUN, cnt 0, which aborts any bubble sequence.
  4. istall: all loads 0.
  5. Bubble, when (S_RUN & bubble_enable) or S_BUBBLE: load_pc 0, load_if_id 0, load_id_ex 1 with bubble_id_ex 1, load_ex_mem 1, load_mem_wb 1.
     - From S_RUN: if BUBBLE_CYCLES == 1, stay S_RUN; else go to S_BUBBLE with cnt = BUBBLE_CYCLES-1.
     - In S_BUBBLE: cnt decrements; when cnt == 1, next state S_RUN. bubble_enable is ignored in S_BUBBLE.
  6. Otherwise: all loads 1.
- stall_active = ~(all five loads 1) outside reset.
- Counters (when enabled) increment once per cycle of matching rule:
  - dstall: rule 1.
  - istall: rules 2 and 4.
  - bubble: rule 5.
  - flush: rule 3.
  - All counters saturate at all-ones. perf_clr zeroes all counters and wins over increment.
- Reset mid-bubble: returns to S_RUN on the next edge; no residual bubble.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: the four saturating counters exist as specified.
- Undefined: counter logic is omitted, perf_* ports are driven constant 0, and perf_clr is ignored.
- Stall and flush behaviour is identical either way.

Test Plan:
- Load-use, BUBBLE_CYCLES=1: bubble_enable high 1 cycle, no stalls -> that cycle load_pc=0, load_if_id=0, bubble_id_ex=1; next cycle all loads 1; perf_bubble_cnt=1.
- BUBBLE_CYCLES=3: bubble_enable pulse 1 cycle -> exactly 3 consecutive bubble cycles, then all loads 1.
- dmem_read held 4 cycles with dmem_resp on the 4th, during S_BUBBLE cnt=2 -> 3 cycles with all loads 0 and cnt held at 2. Then 2 bubble cycles resume; perf_dstall_cnt=3.
- branch_taken with istall for 2 cycles, then imem_resp -> 2 frozen cycles, then 1 cycle of all loads 1 with all three flushes; perf_istall_cnt=2, perf_flush_cnt=1.
- branch_taken during S_BUBBLE cnt=2 -> flush cycle, next state S_RUN, no further bubbles.
- reset asserted during S_BUBBLE, then 1 clean cycle -> all outputs 0 during reset; next cycle all loads 1 and counters 0.
